// File: rtl/urv_dm_responder_pkg.sv
// Shared constants and types for the uRV data-memory responder.
// Holds the region decode constants, the posted IO write entry layout and status formatting.
package urv_dm_responder_pkg;

    localparam int         URV_DM_IO_BIT        = 31;
    localparam logic [5:0] URV_DM_IO_STATUS_OFS = 6'h0;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  sel;
    } io_entry_t;

    localparam int IO_ENTRY_W = $bits(io_entry_t);

    typedef enum logic [1:0] {
        LD_RAM    = 2'd0,
        LD_STATUS = 2'd1,
        LD_ZERO   = 2'd2
    } ld_src_e;

    function automatic logic [31:0] status_word(input logic full, input logic [3:0] level);
        return {27'b0, full, level};
    endfunction

endpackage

// File: rtl/urv_dm_fifo.sv
// Synchronous posted-write FIFO with occupancy level; head reads as zero while empty.
// Storage has no reset, only pointers and level are cleared.
module urv_dm_fifo #(
    parameter int WIDTH = 68,
    parameter int DEPTH = 4,
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int LW = $clog2(DEPTH + 1)
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty,
    output logic [LW-1:0]    level
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic             push_ok;
    logic             pop_ok;

    assign full    = (level == LW'(DEPTH));
    assign empty   = (level == '0);
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign rdata   = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk_i) begin
        if (push_ok) begin
            mem[wr_ptr] <= wdata;
        end
    end

    // Power-of-two depth lets the pointers wrap by plain overflow.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({push_ok, pop_ok})
                2'b10:   level <= level + LW'(1);
                2'b01:   level <= level - LW'(1);
                default: level <= level;
            endcase
        end
    end

endmodule

// File: rtl/urv_dm_responder.sv
// Data-memory target for the uRV execute stage: local byte-enabled RAM with one-cycle
// load return, plus IO stores posted into a FIFO that drains over valid/ready.
module urv_dm_responder
    import urv_dm_responder_pkg::*;
#(
    parameter int RAM_AW     = 12,
    parameter int FIFO_DEPTH = 4
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic [31:0] dm_addr_i,
    input  logic [31:0] dm_data_s_i,
    input  logic [3:0]  dm_data_select_i,
    input  logic        dm_store_i,
    input  logic        dm_load_i,
    output logic        dm_ready_o,
    output logic [31:0] dm_data_l_o,
    output logic        dm_load_done_o,
    output logic        io_valid_o,
    input  logic        io_ready_i,
    output logic [31:0] io_addr_o,
    output logic [31:0] io_data_o,
    output logic [3:0]  io_sel_o
);

    localparam int LW = $clog2(FIFO_DEPTH + 1);

    logic [31:0]       mem [2**RAM_AW];
    logic [RAM_AW-1:0] ram_idx;
    logic              is_io;
    logic              accept;
    logic              st_acc;
    logic              ld_acc;
    logic              ram_we;
    logic              io_push;
    logic              io_pop;
    logic              fifo_full;
    logic              fifo_empty;
    logic [LW-1:0]     fifo_level;
    logic [3:0]        level4;
    io_entry_t         push_entry;
    io_entry_t         head_entry;
    ld_src_e           ld_src;

    assign is_io   = dm_addr_i[URV_DM_IO_BIT];
    assign ram_idx = dm_addr_i[RAM_AW+1:2];

    // Ready is pulled low during reset and while the FIFO is full, for all request types.
    assign dm_ready_o = rst_n_i && !fifo_full;
    assign accept     = dm_ready_o && (dm_store_i || dm_load_i);
    assign st_acc     = accept && dm_store_i;
    assign ld_acc     = accept && dm_load_i && !dm_store_i;
    assign ram_we     = st_acc && !is_io;
    assign io_push    = st_acc && is_io;
    assign io_pop     = io_valid_o && io_ready_i;
    assign level4     = 4'(fifo_level);

    always_comb begin
        push_entry      = '0;
        push_entry.addr = dm_addr_i;
        push_entry.data = dm_data_s_i;
        push_entry.sel  = dm_data_select_i;
    end

    always_comb begin
        ld_src = LD_ZERO;
        if (!is_io) begin
            ld_src = LD_RAM;
        end else if (dm_addr_i[7:2] == URV_DM_IO_STATUS_OFS) begin
            ld_src = LD_STATUS;
        end
    end

    always_ff @(posedge clk_i) begin
        if (ram_we) begin
            for (int b = 0; b < 4; b++) begin
                if (dm_data_select_i[b]) begin
                    mem[ram_idx][8*b +: 8] <= dm_data_s_i[8*b +: 8];
                end
            end
        end
    end

    // Load data is held between completions; only the done pulse is per-cycle.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            dm_data_l_o    <= '0;
            dm_load_done_o <= 1'b0;
        end else begin
            dm_load_done_o <= ld_acc;
            if (ld_acc) begin
                case (ld_src)
                    LD_RAM:    dm_data_l_o <= mem[ram_idx];
                    LD_STATUS: dm_data_l_o <= status_word(fifo_full, level4);
                    default:   dm_data_l_o <= '0;
                endcase
            end
        end
    end

    urv_dm_fifo #(
        .WIDTH (IO_ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .push    (io_push),
        .wdata   (push_entry),
        .pop     (io_pop),
        .rdata   (head_entry),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .level   (fifo_level)
    );

    assign io_valid_o = !fifo_empty;
    assign io_addr_o  = head_entry.addr;
    assign io_data_o  = head_entry.data;
    assign io_sel_o   = head_entry.sel;

endmodule

// File: tb/tb_urv_dm_responder.sv
// Self-checking bench for urv_dm_responder: directed scenarios plus a randomized run,
// all checked against a queue/array reference model of the responder's behaviour.
module tb_urv_dm_responder;

    localparam int DEPTH = 4;
    localparam int AW    = 12;

    logic        clk_i = 1'b0;
    logic        rst_n_i;
    logic [31:0] dm_addr_i;
    logic [31:0] dm_data_s_i;
    logic [3:0]  dm_data_select_i;
    logic        dm_store_i;
    logic        dm_load_i;
    logic        dm_ready_o;
    logic [31:0] dm_data_l_o;
    logic        dm_load_done_o;
    logic        io_valid_o;
    logic        io_ready_i;
    logic [31:0] io_addr_o;
    logic [31:0] io_data_o;
    logic [3:0]  io_sel_o;

    urv_dm_responder #(.RAM_AW(AW), .FIFO_DEPTH(DEPTH)) dut (
        .clk_i            (clk_i),
        .rst_n_i          (rst_n_i),
        .dm_addr_i        (dm_addr_i),
        .dm_data_s_i      (dm_data_s_i),
        .dm_data_select_i (dm_data_select_i),
        .dm_store_i       (dm_store_i),
        .dm_load_i        (dm_load_i),
        .dm_ready_o       (dm_ready_o),
        .dm_data_l_o      (dm_data_l_o),
        .dm_load_done_o   (dm_load_done_o),
        .io_valid_o       (io_valid_o),
        .io_ready_i       (io_ready_i),
        .io_addr_o        (io_addr_o),
        .io_data_o        (io_data_o),
        .io_sel_o         (io_sel_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] d;
        logic [3:0]  s;
    } ent_t;

    ent_t        q[$];
    logic [31:0] ram_m [int];
    logic [31:0] exp_data;
    logic        exp_done;
    logic        exp_ready;
    logic        exp_valid;
    ent_t        exp_head;
    int          n_run  = 0;
    int          n_fail = 0;

    task automatic drive(input bit ld, input bit st, input logic [31:0] a,
                         input logic [31:0] d, input logic [3:0] s);
        dm_load_i        = ld;
        dm_store_i       = st;
        dm_addr_i        = a;
        dm_data_s_i      = d;
        dm_data_select_i = s;
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    endtask

    // Reference model: advance one clock with the currently driven inputs.
    task automatic step();
        bit          rdy, acc, st, ld, pop;
        int          idx;
        logic [31:0] w;
        ent_t        e;
        rdy = (q.size() != DEPTH);
        st  = dm_store_i;
        ld  = dm_load_i && !dm_store_i;
        acc = rdy && (dm_store_i || dm_load_i);
        pop = (q.size() != 0) && io_ready_i;
        idx = int'(dm_addr_i[AW+1:2]);
        exp_done = acc && ld;
        if (exp_done) begin
            if (!dm_addr_i[31])
                exp_data = ram_m.exists(idx) ? ram_m[idx] : 32'h0;
            else if (dm_addr_i[7:2] == 6'd0)
                exp_data = q.size() + ((q.size() == DEPTH) ? 32'd16 : 32'd0);
            else
                exp_data = 32'h0;
        end
        if (pop) void'(q.pop_front());
        if (acc && st) begin
            if (dm_addr_i[31]) begin
                e.a = dm_addr_i;
                e.d = dm_data_s_i;
                e.s = dm_data_select_i;
                q.push_back(e);
            end else begin
                w = ram_m.exists(idx) ? ram_m[idx] : 32'h0;
                for (int b = 0; b < 4; b++)
                    if (dm_data_select_i[b]) w[8*b +: 8] = dm_data_s_i[8*b +: 8];
                ram_m[idx] = w;
            end
        end
        @(posedge clk_i);
        #1;
        exp_ready = (q.size() != DEPTH);
        exp_valid = (q.size() != 0);
        exp_head  = exp_valid ? q[0] : '0;
    endtask

    task automatic drain();
        io_ready_i = 1'b1;
        idle();
        for (int i = 0; i < 20 && exp_valid; i++) step();
        n_run++;
        if (io_valid_o !== 1'b0 || exp_valid) begin
            n_fail++;
            $display("FAIL drain_empty: io_valid got %0b want 0", io_valid_o);
        end
    endtask

    task automatic test_reset();
        rst_n_i    = 1'b0;
        io_ready_i = 1'b0;
        idle();
        #1;
        n_run++;
        if (dm_ready_o !== 1'b0 || dm_load_done_o !== 1'b0 || io_valid_o !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_ctrl: ready/done/valid got %0b%0b%0b want 000",
                     dm_ready_o, dm_load_done_o, io_valid_o);
        end
        n_run++;
        if (dm_data_l_o !== 32'h0 || io_addr_o !== 32'h0 || io_data_o !== 32'h0 || io_sel_o !== 4'h0) begin
            n_fail++;
            $display("FAIL reset_data: data_l %h addr %h data %h sel %h want zeros",
                     dm_data_l_o, io_addr_o, io_data_o, io_sel_o);
        end
        repeat (2) @(posedge clk_i);
        #1;
        rst_n_i   = 1'b1;
        exp_data  = 32'h0;
        exp_done  = 1'b0;
        exp_ready = 1'b1;
        exp_valid = 1'b0;
        exp_head  = '0;
        #1;
        n_run++;
        if (dm_ready_o !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_release_ready: got %0b want 1", dm_ready_o);
        end
    endtask

    task automatic test_ram_lanes();
        drive(1'b0, 1'b1, 32'h100, 32'hDEADBEEF, 4'b1111); step();
        drive(1'b0, 1'b1, 32'h100, 32'hAAAAAAAA, 4'b0010); step();
        drive(1'b1, 1'b0, 32'h100, 32'h0, 4'h0);           step();
        idle();
        n_run++;
        if (dm_load_done_o !== 1'b1 || dm_data_l_o !== 32'hDEADAAEF || exp_data !== 32'hDEADAAEF) begin
            n_fail++;
            $display("FAIL ram_lanes: done %0b data %h want done 1 data deadaaef",
                     dm_load_done_o, dm_data_l_o);
        end
        step();
        n_run++;
        if (dm_load_done_o !== 1'b0 || dm_data_l_o !== 32'hDEADAAEF) begin
            n_fail++;
            $display("FAIL ram_hold: done %0b data %h want done 0 data deadaaef",
                     dm_load_done_o, dm_data_l_o);
        end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 1'b1, 32'(4 * i), 32'(i + 1), 4'hF);
            step();
        end
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 1'b0, 32'(4 * i), 32'h0, 4'h0);
            n_run++;
            if (dm_ready_o !== 1'b1) begin
                n_fail++;
                $display("FAIL b2b_ready[%0d]: got %0b want 1", i, dm_ready_o);
            end
            step();
            n_run++;
            if (dm_load_done_o !== 1'b1 || dm_data_l_o !== 32'(i + 1) || exp_data !== 32'(i + 1)) begin
                n_fail++;
                $display("FAIL b2b_load[%0d]: done %0b data %h want done 1 data %h",
                         i, dm_load_done_o, dm_data_l_o, i + 1);
            end
        end
        idle();
    endtask

    task automatic test_fifo_fill();
        io_ready_i = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            drive(1'b0, 1'b1, 32'h80000010, 32'(k), 4'hF);
            n_run++;
            if (io_valid_o !== (k > 1)) begin
                n_fail++;
                $display("FAIL fill_valid[%0d]: got %0b want %0b", k, io_valid_o, k > 1);
            end
            step();
            n_run++;
            if (dm_ready_o !== (k < 4) || dm_ready_o !== exp_ready) begin
                n_fail++;
                $display("FAIL fill_ready[%0d]: got %0b want %0b", k, dm_ready_o, k < 4);
            end
        end
        drive(1'b1, 1'b0, 32'h80000000, 32'h0, 4'h0);
        step();
        n_run++;
        if (dm_load_done_o !== 1'b0 || exp_done) begin
            n_fail++;
            $display("FAIL fill_status_blocked: done got %0b want 0", dm_load_done_o);
        end
        idle();
        io_ready_i = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            n_run++;
            if (io_valid_o !== 1'b1 || io_data_o !== 32'(k) || io_addr_o !== 32'h80000010 || io_sel_o !== 4'hF) begin
                n_fail++;
                $display("FAIL drain_order[%0d]: valid %0b addr %h data %h sel %h want 1 80000010 %h f",
                         k, io_valid_o, io_addr_o, io_data_o, io_sel_o, k);
            end
            step();
            n_run++;
            if (dm_ready_o !== 1'b1) begin
                n_fail++;
                $display("FAIL drain_ready[%0d]: got %0b want 1", k, dm_ready_o);
            end
        end
        n_run++;
        if (io_valid_o !== 1'b0) begin
            n_fail++;
            $display("FAIL drain_done_valid: got %0b want 0", io_valid_o);
        end
    endtask

    task automatic test_status();
        io_ready_i = 1'b0;
        drive(1'b0, 1'b1, 32'h80000040, 32'h11, 4'h1); step();
        drive(1'b0, 1'b1, 32'h80000044, 32'h22, 4'h2); step();
        n_run++;
        if (io_valid_o !== 1'b1 || io_data_o !== 32'h11 || io_sel_o !== 4'h1) begin
            n_fail++;
            $display("FAIL status_head: valid %0b data %h sel %h want 1 11 1",
                     io_valid_o, io_data_o, io_sel_o);
        end
        drive(1'b1, 1'b0, 32'h80000000, 32'h0, 4'h0); step();
        n_run++;
        if (dm_load_done_o !== 1'b1 || dm_data_l_o !== 32'h2 || exp_data !== 32'h2) begin
            n_fail++;
            $display("FAIL status_level2: done %0b data %h want 1 00000002", dm_load_done_o, dm_data_l_o);
        end
        drive(1'b1, 1'b0, 32'h80000004, 32'h0, 4'h0); step();
        n_run++;
        if (dm_load_done_o !== 1'b1 || dm_data_l_o !== 32'h0) begin
            n_fail++;
            $display("FAIL status_other_ofs: done %0b data %h want 1 0", dm_load_done_o, dm_data_l_o);
        end
        drain();
    endtask

    task automatic test_push_pop();
        io_ready_i = 1'b1;
        for (int k = 0; k < 8; k++) begin
            drive(1'b0, 1'b1, 32'h80000020 + 32'(4 * k), 32'h100 + 32'(k), 4'hC);
            step();
            n_run++;
            if (dm_ready_o !== 1'b1 || io_valid_o !== 1'b1 || io_data_o !== 32'h100 + 32'(k)) begin
                n_fail++;
                $display("FAIL pushpop[%0d]: ready %0b valid %0b data %h want 1 1 %h",
                         k, dm_ready_o, io_valid_o, io_data_o, 32'h100 + 32'(k));
            end
        end
        io_ready_i = 1'b0;
        drive(1'b1, 1'b0, 32'h80000000, 32'h0, 4'h0);
        step();
        n_run++;
        if (dm_data_l_o !== 32'h1 || exp_data !== 32'h1) begin
            n_fail++;
            $display("FAIL pushpop_level: status %h want 00000001", dm_data_l_o);
        end
        drain();
    endtask

    task automatic test_async_reset();
        io_ready_i = 1'b0;
        for (int k = 0; k < 3; k++) begin
            drive(1'b0, 1'b1, 32'h80000100, 32'(k + 7), 4'hF);
            step();
        end
        idle();
        io_ready_i = 1'b1;
        step();
        n_run++;
        if (io_valid_o !== 1'b1 || io_data_o !== 32'd8) begin
            n_fail++;
            $display("FAIL arst_pre: valid %0b data %h want 1 8", io_valid_o, io_data_o);
        end
        #2;
        rst_n_i = 1'b0;
        #1;
        n_run++;
        if (io_valid_o !== 1'b0 || dm_ready_o !== 1'b0 || io_data_o !== 32'h0) begin
            n_fail++;
            $display("FAIL arst_immediate: valid %0b ready %0b data %h want 0 0 0",
                     io_valid_o, dm_ready_o, io_data_o);
        end
        q.delete();
        exp_data  = 32'h0;
        exp_done  = 1'b0;
        exp_valid = 1'b0;
        exp_head  = '0;
        @(posedge clk_i);
        #1;
        rst_n_i = 1'b1;
        exp_ready = 1'b1;
        drive(1'b1, 1'b0, 32'h80000000, 32'h0, 4'h0);
        step();
        idle();
        n_run++;
        if (dm_load_done_o !== 1'b1 || dm_data_l_o !== 32'h0 || io_valid_o !== 1'b0) begin
            n_fail++;
            $display("FAIL arst_status: done %0b data %h valid %0b want 1 0 0",
                     dm_load_done_o, dm_data_l_o, io_valid_o);
        end
    endtask

    task automatic test_random();
        int          pool [16];
        int          r, idx;
        logic [31:0] a;
        for (int i = 0; i < 16; i++) begin
            pool[i] = $urandom_range(0, 2**AW - 1);
            a = {1'b0, 17'($urandom), 12'(pool[i]), 2'($urandom)};
            drive(1'b0, 1'b1, a, $urandom, 4'hF);
            step();
        end
        for (int c = 0; c < 400; c++) begin
            io_ready_i = ($urandom_range(0, 2) != 0);
            r   = $urandom_range(0, 9);
            idx = pool[$urandom_range(0, 15)];
            a   = {1'b0, 17'($urandom), 12'(idx), 2'($urandom)};
            case (r)
                0, 1, 2: drive(1'b1, 1'b0, a, 32'h0, 4'h0);
                3, 4:    drive(1'b0, 1'b1, a, $urandom, 4'($urandom));
                5, 6:    drive(1'b0, 1'b1, {1'b1, 31'($urandom)}, $urandom, 4'($urandom));
                7:       drive(1'b1, 1'b0, {1'b1, 23'($urandom), 8'($urandom_range(0, 3))}, 32'h0, 4'h0);
                8:       drive(1'b1, 1'b0, {1'b1, 23'($urandom), 6'($urandom_range(1, 63)), 2'b0}, 32'h0, 4'h0);
                default: drive(1'b1, 1'b1, a, $urandom, 4'($urandom));
            endcase
            if (q.size() == DEPTH && $urandom_range(0, 3) != 0) idle();
            step();
            n_run++;
            if (dm_ready_o !== exp_ready || dm_load_done_o !== exp_done || dm_data_l_o !== exp_data) begin
                n_fail++;
                $display("FAIL rand_core[%0d]: ready %0b done %0b data %h want %0b %0b %h",
                         c, dm_ready_o, dm_load_done_o, dm_data_l_o, exp_ready, exp_done, exp_data);
            end
            n_run++;
            if (io_valid_o !== exp_valid || io_addr_o !== exp_head.a || io_data_o !== exp_head.d || io_sel_o !== exp_head.s) begin
                n_fail++;
                $display("FAIL rand_io[%0d]: valid %0b addr %h data %h sel %h want %0b %h %h %h",
                         c, io_valid_o, io_addr_o, io_data_o, io_sel_o,
                         exp_valid, exp_head.a, exp_head.d, exp_head.s);
            end
        end
        drain();
    endtask

    initial begin
        test_reset();
        test_ram_lanes();
        test_back_to_back();
        test_fifo_fill();
        test_status();
        test_push_pop();
        test_async_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, got no finish want finish");
        $fatal(1, "watchdog expired");
    end

endmodule
